reservation_station: RTL
========================

# reservation_station

Tomasulo-style reservation station that sits directly downstream of the register rename map table and decode/dispatch. Each dispatched instruction arrives with per-source ROB tag, ready flag and (when ready) operand value. The station holds the instruction until both operands are known, snooping the common data bus (CDB) for producer results, then issues it to one functional unit through a valid/ready handshake.

## Interface
- RS_SIZE, 4, number of entries (power of two, 2..16)
- TAG_W, 3, ROB tag width (equals `ROB_TAG_LEN)
- DATA_W, 32, operand and CDB value width
- PAYLOAD_W, 32, opaque instruction payload (opcode, immediate, PC) carried to the FU unchanged

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- dispatch_valid  in  1  allocate an entry this cycle
- dispatch_dest_tag  in  TAG_W  ROB entry of this instruction
- dispatch_payload  in  PAYLOAD_W  opaque instruction bits
- dispatch_rs1_ready / dispatch_rs2_ready  in  1 each  operand value valid (map-table ready flag, or unmapped)
- dispatch_rs1_tag / dispatch_rs2_tag  in  TAG_W each  producer ROB tag when not ready
- dispatch_rs1_value / dispatch_rs2_value  in  DATA_W each  operand value when ready
- full  out  1  every entry occupied; dispatch_valid is ignored while high
- cdb_valid  in  1  result broadcast this cycle
- cdb_tag  in  TAG_W  ROB tag of the broadcast result
- cdb_value  in  DATA_W  broadcast value
- flush  in  1  squash all entries (branch mispredict)
- issue_valid  out  1  an entry is ready to issue
- issue_ready  in  1  FU accepts this cycle
- issue_dest_tag  out  TAG_W; issue_payload  out  PAYLOAD_W; issue_rs1_value / issue_rs2_value  out  DATA_W each

## Operation
- Per entry: valid, dest_tag, payload; per operand: ready, tag, value.
- Allocation: on dispatch_valid && !full, write the lowest-index entry whose registered valid bit is 0. A slot freed by issue in the same cycle is not reused until the next cycle.
- Dispatch-time forwarding: if an incoming operand has ready=0 and cdb_valid && cdb_tag == its tag in the same cycle, store it as ready=1 with value=cdb_value.
- Wakeup: every valid entry's not-ready operand with tag == cdb_tag on cdb_valid latches cdb_value and sets ready=1. Both operands of one entry may wake on the same broadcast. Already-ready operands ignore the CDB.
- Select: issue candidate is the lowest-index entry with valid and both operands ready in registered state. issue_valid and issue_* are combinational from registered state only; no CDB bypass to issue.
- Handshake: when issue_valid && issue_ready, the selected entry's valid clears at the edge. When issue_ready=0, outputs hold and the entry is retained. issue_* are don't-care while issue_valid=0.
- full = AND of all registered valid bits.
- Flush is synchronous and overrides dispatch, wakeup and issue: all valid bits clear at the edge. issue_valid may be high in the flush cycle, but an issue completes only if issue_ready is also high; the FU must itself discard it.
- Reset (asynchronous, reset_n=0): all valid and ready bits clear. Outputs: issue_valid=0, full=0. Tag, value and payload registers also reset to 0. Assertion mid-operation drops all entries immediately.

## Timing
- Dispatch with both operands ready at edge N: issue_valid high during cycle N+1. Minimum dispatch-to-issue latency is 1 cycle.
- CDB wakeup during cycle N: entry eligible in cycle N+1.
- Issue and dispatch in the same cycle are independent. Occupancy is unchanged; full is recomputed from the new state at N+1.
- Dispatch while full: ignored with no state change.

## Test plan
- Reset and basic issue: with reset_n low, issue_valid=0 and full=0. Release, dispatch tag 5 with rs1=10 and rs2=20 both ready, issue_ready=1 → next cycle issue_valid=1, dest_tag=5, values 10/20. One cycle later issue_valid=0.
- Wakeup: dispatch tag 2 with rs1 waiting on tag 3. Two cycles later CDB tag 3 value 0xABCD → issue_valid rises the following cycle with rs1_value=0xABCD.
- Same-cycle forwarding: dispatch rs2 waiting on tag 6 while cdb_valid with tag 6, value 7 → entry issues the next cycle with rs2_value=7.
- Fill and stall: hold issue_ready=0, dispatch 4 ready instructions with tags 1–4 → full=1. A 5th dispatch is ignored. Raise issue_ready → tags issue in index order 1, 2, 3, 4 on consecutive cycles; full drops after the first issue.
- Flush: 3 entries occupied, assert flush together with dispatch_valid and cdb_valid → next cycle full=0, issue_valid=0, no entry allocated.
- Async reset mid-stream: drop reset_n between clock edges while entries are valid → issue_valid falls immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station
// Tomasulo-style reservation station. Dispatched instructions wait here until
// both source operands are known. While they wait, each missing operand
// watches the common data bus for its producer's tag. The lowest-index entry
// with both operands ready is offered to a single functional unit through a
// valid/ready handshake.
//
// Ports:
//   clock, reset_n                 rising-edge clock, async active-low reset
//   dispatch_*                     new instruction: dest tag, payload, and per
//                                  source a ready flag, producer tag and value
//   full                           every entry occupied; dispatch is ignored
//   cdb_valid/cdb_tag/cdb_value    result broadcast snooped by waiting operands
//   flush                          squash all entries at the next edge
//   issue_valid/issue_ready        handshake toward the functional unit
//   issue_dest_tag/issue_payload/
//   issue_rs1_value/issue_rs2_value  selected entry contents
module reservation_station #(
  parameter int RS_SIZE   = 4,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 dispatch_valid,
  input  logic [TAG_W-1:0]     dispatch_dest_tag,
  input  logic [PAYLOAD_W-1:0] dispatch_payload,
  input  logic                 dispatch_rs1_ready,
  input  logic                 dispatch_rs2_ready,
  input  logic [TAG_W-1:0]     dispatch_rs1_tag,
  input  logic [TAG_W-1:0]     dispatch_rs2_tag,
  input  logic [DATA_W-1:0]    dispatch_rs1_value,
  input  logic [DATA_W-1:0]    dispatch_rs2_value,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [DATA_W-1:0]    cdb_value,
  input  logic                 flush,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [TAG_W-1:0]     issue_dest_tag,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [DATA_W-1:0]    issue_rs1_value,
  output logic [DATA_W-1:0]    issue_rs2_value
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]   valid_q;
  logic [RS_SIZE-1:0]   rs1_ready_q;
  logic [RS_SIZE-1:0]   rs2_ready_q;
  logic [TAG_W-1:0]     dest_tag_q  [RS_SIZE];
  logic [PAYLOAD_W-1:0] payload_q   [RS_SIZE];
  logic [TAG_W-1:0]     rs1_tag_q   [RS_SIZE];
  logic [TAG_W-1:0]     rs2_tag_q   [RS_SIZE];
  logic [DATA_W-1:0]    rs1_value_q [RS_SIZE];
  logic [DATA_W-1:0]    rs2_value_q [RS_SIZE];

  logic [RS_SIZE-1:0]   eligible;
  logic [IDX_W-1:0]     alloc_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic                 dispatch_fire;
  logic                 issue_fire;
  logic                 rs1_fwd;
  logic                 rs2_fwd;
  logic                 new_rs1_ready;
  logic                 new_rs2_ready;
  logic [DATA_W-1:0]    new_rs1_value;
  logic [DATA_W-1:0]    new_rs2_value;

  assign full          = &valid_q;
  assign eligible      = valid_q & rs1_ready_q & rs2_ready_q;
  assign issue_valid   = |eligible;
  assign issue_fire    = issue_valid && issue_ready;
  assign dispatch_fire = dispatch_valid && !full;

  // Lowest-index free slot and lowest-index ready entry. Scanning from the
  // top down lets the last hit (lowest index) win. Both use registered state
  // only, so a slot freed by this cycle's issue is not reused until next cycle.
  always_comb begin
    alloc_idx = '0;
    sel_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
      if (eligible[i]) sel_idx = IDX_W'(i);
    end
  end

  // A source that is still waiting at dispatch can catch its producer on the
  // CDB in the very same cycle; otherwise it would miss the broadcast forever.
  always_comb begin
    rs1_fwd       = !dispatch_rs1_ready && cdb_valid && (cdb_tag == dispatch_rs1_tag);
    rs2_fwd       = !dispatch_rs2_ready && cdb_valid && (cdb_tag == dispatch_rs2_tag);
    new_rs1_ready = dispatch_rs1_ready | rs1_fwd;
    new_rs2_ready = dispatch_rs2_ready | rs2_fwd;
    new_rs1_value = rs1_fwd ? cdb_value : dispatch_rs1_value;
    new_rs2_value = rs2_fwd ? cdb_value : dispatch_rs2_value;
  end

  assign issue_dest_tag  = dest_tag_q[sel_idx];
  assign issue_payload   = payload_q[sel_idx];
  assign issue_rs1_value = rs1_value_q[sel_idx];
  assign issue_rs2_value = rs2_value_q[sel_idx];

  // Entry state. Flush simply drops every valid bit; stale contents are
  // harmless because they are overwritten on the next allocation. The
  // allocated slot is always an invalid one, so it never collides with the
  // wakeup or issue updates of the same entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      rs1_ready_q <= '0;
      rs2_ready_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        dest_tag_q[i]  <= '0;
        payload_q[i]   <= '0;
        rs1_tag_q[i]   <= '0;
        rs2_tag_q[i]   <= '0;
        rs1_value_q[i] <= '0;
        rs2_value_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid_q[i] && !rs1_ready_q[i] && cdb_valid && (cdb_tag == rs1_tag_q[i])) begin
          rs1_ready_q[i] <= 1'b1;
          rs1_value_q[i] <= cdb_value;
        end
        if (valid_q[i] && !rs2_ready_q[i] && cdb_valid && (cdb_tag == rs2_tag_q[i])) begin
          rs2_ready_q[i] <= 1'b1;
          rs2_value_q[i] <= cdb_value;
        end
        if (issue_fire && (sel_idx == IDX_W'(i))) begin
          valid_q[i] <= 1'b0;
        end
        if (dispatch_fire && (alloc_idx == IDX_W'(i))) begin
          valid_q[i]     <= 1'b1;
          dest_tag_q[i]  <= dispatch_dest_tag;
          payload_q[i]   <= dispatch_payload;
          rs1_ready_q[i] <= new_rs1_ready;
          rs2_ready_q[i] <= new_rs2_ready;
          rs1_tag_q[i]   <= dispatch_rs1_tag;
          rs2_tag_q[i]   <= dispatch_rs2_tag;
          rs1_value_q[i] <= new_rs1_value;
          rs2_value_q[i] <= new_rs2_value;
        end
      end
    end
  end

endmodule
